// File: rtl/stack_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stack_ctrl_pkg : state encoding and default stack bounds          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package stack_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH_WR  = 3'd1,
    ST_PUSH_DEC = 3'd2,
    ST_POP_INC  = 3'd3,
    ST_POP_RD   = 3'd4,
    ST_POP_CAP  = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERR      = 3'd7
  } state_t;

  localparam logic [15:0] c_stack_top   = 16'h01FF;
  localparam logic [15:0] c_stack_base  = 16'h0100;
  localparam int          c_mem_latency = 1;

endpackage
`default_nettype wire

// File: rtl/stack_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stack_ctrl_if : request, SP-register and RAM signals of stack_ctrl|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface stack_ctrl_if #(
  parameter int DATA_W = 16
) ();

  logic              push_req;
  logic              pop_req;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] pop_data;
  logic              busy;
  logic              done;
  logic              err;
  logic              full;
  logic              empty;
  logic [15:0]       sp_val;
  logic              sp_inc;
  logic              sp_dec;
  logic [15:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  push_req, pop_req, push_data, sp_val, mem_rdata,
    output pop_data, busy, done, err, full, empty,
           sp_inc, sp_dec, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output push_req, pop_req, push_data, sp_val, mem_rdata,
    input  pop_data, busy, done, err, full, empty,
           sp_inc, sp_dec, mem_addr, mem_wdata, mem_we, mem_re
  );

endinterface
`default_nettype wire

// File: rtl/stack_bounds.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stack_bounds : combinational full/empty compare on the SP value   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module stack_bounds
  import stack_ctrl_pkg::*;
#(
  parameter logic [15:0] STACK_TOP  = c_stack_top,
  parameter logic [15:0] STACK_BASE = c_stack_base
) (
  input  wire logic [15:0] sp_val,
  output logic             full,
  output logic             empty
);

  assign full  = (sp_val < STACK_BASE);
  assign empty = (sp_val == STACK_TOP);

endmodule
`default_nettype wire

// File: rtl/stack_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stack_ctrl : push/pop sequencer for SP register and stack RAM     |
// | Option macro STACK_CTRL_GUARD_EN enables overflow/underflow guard |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int          DATA_W     = 16,
  parameter logic [15:0] STACK_TOP  = c_stack_top,
  parameter logic [15:0] STACK_BASE = c_stack_base
) (
  input  wire logic   clk,
  input  wire logic   rst,
  stack_ctrl_if.slave bus
);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_push_data;
  logic [DATA_W-1:0] r_pop_data;
  logic              w_full;
  logic              w_empty;

`ifdef STACK_CTRL_GUARD_EN
  stack_bounds #(
    .STACK_TOP  (STACK_TOP),
    .STACK_BASE (STACK_BASE)
  ) u_bounds (
    .sp_val (bus.sp_val),
    .full   (w_full),
    .empty  (w_empty)
  );
`else
  // Without the guard every request executes and SP wraps in the SP register.
  logic w_unused_bounds;
  assign w_unused_bounds = ^{STACK_TOP, STACK_BASE};
  assign w_full          = 1'b0;
  assign w_empty         = 1'b0;
`endif

  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.pop_data = r_pop_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_push_data <= '0;
      r_pop_data  <= '0;
    end else begin
      if (r_state == ST_IDLE && bus.push_req && !w_full) begin
        r_push_data <= bus.push_data;
      end
      // RAM read data arrives one cycle after the POP_RD strobe.
      if (r_state == ST_POP_CAP) begin
        r_pop_data <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.busy      = (r_state != ST_IDLE);
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    bus.sp_inc    = 1'b0;
    bus.sp_dec    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_addr  = 16'h0000;
    bus.mem_wdata = '0;
    case (r_state)
      ST_IDLE: begin
        // Push wins a tie; a simultaneous pop is dropped, not queued.
        if (bus.push_req) begin
          w_next = w_full ? ST_ERR : ST_PUSH_WR;
        end else if (bus.pop_req) begin
          w_next = w_empty ? ST_ERR : ST_POP_INC;
        end
      end
      ST_PUSH_WR: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = bus.sp_val;
        bus.mem_wdata = r_push_data;
        w_next        = ST_PUSH_DEC;
      end
      ST_PUSH_DEC: begin
        bus.sp_dec = 1'b1;
        w_next     = ST_DONE;
      end
      ST_POP_INC: begin
        bus.sp_inc = 1'b1;
        w_next     = ST_POP_RD;
      end
      ST_POP_RD: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = bus.sp_val;
        w_next       = ST_POP_CAP;
      end
      ST_POP_CAP: begin
        w_next = ST_DONE;
      end
      ST_DONE: begin
        bus.done = 1'b1;
        w_next   = ST_IDLE;
      end
      ST_ERR: begin
        bus.err = 1'b1;
        w_next  = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_stack_ctrl : scoreboard bench with SP-register and RAM models  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_stack_ctrl;

`ifdef STACK_CTRL_GUARD_EN
  localparam bit c_guard = 1'b1;
`else
  localparam bit c_guard = 1'b0;
`endif

  typedef struct packed {
    logic        is_err;
    logic [3:0]  end_cyc;
    logic [3:0]  we_cyc;
    logic [15:0] we_addr;
    logic [15:0] we_data;
    logic [3:0]  dec_cyc;
    logic [3:0]  inc_cyc;
    logic [3:0]  re_cyc;
    logic [15:0] re_addr;
    logic [3:0]  n_strobe;
    logic [15:0] pop_data;
    logic [15:0] sp;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stack_ctrl_if #(.DATA_W(16)) sif ();

  stack_ctrl #(
    .DATA_W     (16),
    .STACK_TOP  (16'h01FF),
    .STACK_BASE (16'h0100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  // SP register and RAM environment models
  logic        sp_load = 1'b0;
  logic [15:0] sp_load_val = 16'h0000;
  logic [15:0] ram [0:1023];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             sif.sp_val <= 16'h01FF;
    else if (sp_load)     sif.sp_val <= sp_load_val;
    else if (sif.sp_inc)  sif.sp_val <= sif.sp_val + 16'h0001;
    else if (sif.sp_dec)  sif.sp_val <= sif.sp_val - 16'h0001;
  end

  always_ff @(posedge clk) begin
    if (sif.mem_we) ram[sif.mem_addr[9:0]] <= sif.mem_wdata;
    if (sif.mem_re) sif.mem_rdata <= ram[sif.mem_addr[9:0]];
  end

  int          n_cmp  = 0;
  int          n_fail = 0;
  rec_t        exp_q[$];
  logic [15:0] exp_mem [0:1023];
  logic [15:0] exp_sp  = 16'h01FF;
  logic [15:0] exp_pop = 16'h0000;

  function automatic string fmt(rec_t r);
    return $sformatf("err=%0d end=%0d we=%0d@%h:%h dec=%0d inc=%0d re=%0d@%h nstb=%0d pop=%h sp=%h",
                     r.is_err, r.end_cyc, r.we_cyc, r.we_addr, r.we_data, r.dec_cyc,
                     r.inc_cyc, r.re_cyc, r.re_addr, r.n_strobe, r.pop_data, r.sp);
  endfunction

  // Monitor: builds a trace per operation and scores it on done/err
  int   cyc = 0;
  rec_t act = '0;
  rec_t e_rec;
  int   stb;
  always @(negedge clk) begin
    if (!rst) begin
      cyc = 0;
      act = '0;
    end else if (sif.busy || sif.done || sif.err) begin
      cyc = cyc + 1;
      stb = int'(sif.mem_we) + int'(sif.mem_re) + int'(sif.sp_inc) + int'(sif.sp_dec);
      act.n_strobe = act.n_strobe + 4'(stb);
      if (sif.mem_we) begin
        act.we_cyc  = 4'(cyc);
        act.we_addr = sif.mem_addr;
        act.we_data = sif.mem_wdata;
      end
      if (sif.mem_re) begin
        act.re_cyc  = 4'(cyc);
        act.re_addr = sif.mem_addr;
      end
      if (sif.sp_dec) act.dec_cyc = 4'(cyc);
      if (sif.sp_inc) act.inc_cyc = 4'(cyc);
      if (sif.done || sif.err) begin
        act.is_err   = sif.err;
        act.end_cyc  = 4'(cyc);
        act.pop_data = sif.pop_data;
        act.sp       = sif.sp_val;
        n_cmp = n_cmp + 1;
        if (exp_q.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL unexpected_completion: got %s required none", fmt(act));
        end else begin
          e_rec = exp_q.pop_front();
          if (act !== e_rec) begin
            n_fail = n_fail + 1;
            $display("FAIL op_trace: got %s required %s", fmt(act), fmt(e_rec));
          end
        end
        act = '0;
        cyc = 0;
      end
    end else begin
      cyc = 0;
      n_cmp = n_cmp + 1;
      if (sif.mem_we || sif.mem_re || sif.sp_inc || sif.sp_dec || sif.mem_addr != 16'h0) begin
        n_fail = n_fail + 1;
        $display("FAIL idle_quiet: got we=%0d re=%0d inc=%0d dec=%0d addr=%h required all 0",
                 sif.mem_we, sif.mem_re, sif.sp_inc, sif.sp_dec, sif.mem_addr);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] a, input logic [15:0] e);
    n_cmp = n_cmp + 1;
    if (a !== e) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h required %h", name, a, e);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (!sif.busy) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp  = n_cmp + 1;
      n_fail = n_fail + 1;
      $display("FAIL idle_timeout: got busy=1 required busy=0 within 20 cycles");
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst     = 1'b1;
    exp_sp  = 16'h01FF;
    exp_pop = 16'h0000;
  endtask

  task automatic load_sp(input logic [15:0] v);
    sp_load     = 1'b1;
    sp_load_val = v;
    @(negedge clk);
    sp_load = 1'b0;
    exp_sp  = v;
  endtask

  // Called at a negedge while the DUT idles; poke raises requests while busy.
  task automatic issue(input bit do_push, input bit do_pop, input logic [15:0] d, input bit poke);
    rec_t e = '0;
    if (do_push) begin
      if (c_guard && exp_sp < 16'h0100) begin
        e.is_err  = 1'b1;
        e.end_cyc = 4'd1;
      end else begin
        e.end_cyc  = 4'd3;
        e.we_cyc   = 4'd1;
        e.we_addr  = exp_sp;
        e.we_data  = d;
        e.dec_cyc  = 4'd2;
        e.n_strobe = 4'd2;
        exp_mem[exp_sp[9:0]] = d;
        exp_sp = exp_sp - 16'h0001;
      end
    end else if (do_pop) begin
      if (c_guard && exp_sp == 16'h01FF) begin
        e.is_err  = 1'b1;
        e.end_cyc = 4'd1;
      end else begin
        exp_sp     = exp_sp + 16'h0001;
        e.end_cyc  = 4'd4;
        e.inc_cyc  = 4'd1;
        e.re_cyc   = 4'd2;
        e.re_addr  = exp_sp;
        e.n_strobe = 4'd2;
        exp_pop    = exp_mem[exp_sp[9:0]];
      end
    end
    e.pop_data = exp_pop;
    e.sp       = exp_sp;
    exp_q.push_back(e);
    sif.push_req  = do_push;
    sif.pop_req   = do_pop;
    sif.push_data = d;
    @(posedge clk);
    #1;
    sif.push_req  = 1'b0;
    sif.pop_req   = 1'b0;
    sif.push_data = 16'h0000;
    if (poke) begin
      @(negedge clk);
      sif.push_req = 1'b1;
      sif.pop_req  = 1'b1;
      @(negedge clk);
      sif.push_req = 1'b0;
      sif.pop_req  = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    sif.push_req  = 1'b0;
    sif.pop_req   = 1'b0;
    sif.push_data = 16'h0000;
    do_reset();

    chk("rst_busy",  {15'h0, sif.busy},   16'h0);
    chk("rst_done",  {15'h0, sif.done},   16'h0);
    chk("rst_err",   {15'h0, sif.err},    16'h0);
    chk("rst_strb",  {12'h0, sif.sp_inc, sif.sp_dec, sif.mem_we, sif.mem_re}, 16'h0);
    chk("rst_addr",  sif.mem_addr,        16'h0);
    chk("rst_wdata", sif.mem_wdata,       16'h0);
    chk("rst_pop",   sif.pop_data,        16'h0);
    chk("rst_empty", {15'h0, sif.empty},  {15'h0, c_guard});
    chk("rst_full",  {15'h0, sif.full},   16'h0);
    chk("rst_sp",    sif.sp_val,          16'h01FF);

    // Seed the slot above TOP so a wrapped pop reads a known word
    load_sp(16'h0200);
    issue(1'b1, 1'b0, 16'h0C0C, 1'b0);
    issue(1'b1, 1'b0, 16'hBEEF, 1'b0);
    issue(1'b0, 1'b1, 16'h0000, 1'b0);
    chk("empty_after_pop", {15'h0, sif.empty}, {15'h0, c_guard});
    issue(1'b0, 1'b1, 16'h0000, 1'b0);
    do_reset();

    load_sp(16'h0100);
    chk("full_at_base", {15'h0, sif.full}, 16'h0);
    issue(1'b1, 1'b0, 16'h1234, 1'b0);
    chk("full_below_base", {15'h0, sif.full}, {15'h0, c_guard});
    issue(1'b1, 1'b0, 16'h5678, 1'b0);
    do_reset();

    issue(1'b1, 1'b1, 16'hA5A5, 1'b0);
    issue(1'b0, 1'b1, 16'h0000, 1'b0);
    issue(1'b1, 1'b0, 16'h1111, 1'b1);
    issue(1'b1, 1'b0, 16'h0001, 1'b0);
    issue(1'b1, 1'b0, 16'h0002, 1'b0);
    issue(1'b1, 1'b0, 16'h0003, 1'b0);
    for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, 16'h0000, 1'b0);
    chk("lifo_sp", sif.sp_val, 16'h01FF);

    // Reset asserted in the PUSH_DEC cycle
    sif.push_req  = 1'b1;
    sif.push_data = 16'h2222;
    @(posedge clk);
    #1;
    sif.push_req  = 1'b0;
    sif.push_data = 16'h0000;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_busy", {15'h0, sif.busy},   16'h0);
    chk("abort_dec",  {15'h0, sif.sp_dec}, 16'h0);
    chk("abort_done", {15'h0, sif.done},   16'h0);
    chk("abort_sp",   sif.sp_val,          16'h01FF);
    exp_mem[10'h1FF] = 16'h2222;
    exp_sp  = 16'h01FF;
    exp_pop = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_pop_rst", sif.pop_data, 16'h0);
    chk("queue_drained", 16'(exp_q.size()), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
